n64_vinfo_gen: RTL and testbench

// - Derives the per-pixel demux control word for the downstream video demux stage from the raw N64 bus.
// - Generates the RGB phase counter and detects PAL/NTSC and progressive/interlaced from the sync stream.
// - Merges detection results with user config into demuxparams_o = {data_cnt[1:0], vmode, ndo_deblur, n15bit_mode}.
// - Sits between the N64 input pins and n64_vdemux.

---
 rtl/n64_vinfo_gen.sv | 122 ++++++++++++
 tb/tb_n64_vinfo_gen.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_vinfo_gen.sv
// n64_vinfo_gen: per-pixel demux control and video-mode detection from the raw N64 bus.
// Produces the R/G/B phase counter, classifies fields as PAL/NTSC and
// progressive/interlaced from the sync nibble, and merges that with user config.
module n64_vinfo_gen #(
    parameter int color_width   = 7,
    parameter int LINE_CNT_W    = 10,
    parameter int PAL_THRESHOLD = 288
) (
    input  logic                   VCLK,
    input  logic                   nRST,
    input  logic                   nDSYNC,
    input  logic [color_width-1:0] D_i,
    input  logic                   ndeblur_cfg_i,
    input  logic                   n15bit_cfg_i,
    output logic [4:0]             demuxparams_o,
    output logic [1:0]             vinfo_o
);

    // Sync nibble layout on nDSYNC=0 cycles: {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
    localparam int VSYNC_BIT = 3;
    localparam int HSYNC_BIT = 1;

    localparam logic [LINE_CNT_W-1:0] PAL_LINES = LINE_CNT_W'(PAL_THRESHOLD);
    localparam logic [LINE_CNT_W-1:0] LINE_MAX  = {LINE_CNT_W{1'b1}};
    localparam logic [LINE_CNT_W-1:0] LINE_ONE  = LINE_CNT_W'(1);

    logic [1:0]            data_cnt_q,   data_cnt_d;
    logic [3:0]            sync_q,       sync_d;
    logic [LINE_CNT_W-1:0] line_cnt_q,   line_cnt_d;
    logic [LINE_CNT_W-1:0] field_len_q,  field_len_d;
    logic                  vmode_q,      vmode_d;
    logic                  interlaced_q, interlaced_d;
    logic                  ndo_deblur_q, ndo_deblur_d;
    logic                  n15bit_q,     n15bit_d;

    logic sync_cycle;
    logic hsync_fall;
    logic vsync_fall;

    // Upper data bits and the clamp/csync sample bits carry nothing for this block.
    logic unused_bits;
    assign unused_bits = ^{D_i[color_width-1:4], sync_q[2], sync_q[0]};

    // Decode sync edges by comparing this sync sample against the previous one.
    always_comb begin
        sync_cycle = ~nDSYNC;
        hsync_fall = sync_cycle & sync_q[HSYNC_BIT] & ~D_i[HSYNC_BIT];
        vsync_fall = sync_cycle & sync_q[VSYNC_BIT] & ~D_i[VSYNC_BIT];
    end

    // Phase counter: sync cycle loads 1 so the following cycles are R, G, B; an early sync resyncs.
    always_comb begin
        data_cnt_d = data_cnt_q + 2'd1;
        if (sync_cycle) begin
            data_cnt_d = 2'd1;
        end
    end

    // Hold the last sync nibble so edges can be detected on the next sync cycle.
    always_comb begin
        sync_d = sync_q;
        if (sync_cycle) begin
            sync_d = D_i[3:0];
        end
    end

    // Line counting and end-of-field classification; vsync closes the field before the counter restarts.
    always_comb begin
        line_cnt_d   = line_cnt_q;
        field_len_d  = field_len_q;
        vmode_d      = vmode_q;
        interlaced_d = interlaced_q;
        n15bit_d     = n15bit_q;
        if (vsync_fall) begin
            vmode_d      = (line_cnt_q >= PAL_LINES);
            interlaced_d = (line_cnt_q != field_len_q);
            field_len_d  = line_cnt_q;
            n15bit_d     = n15bit_cfg_i;
            line_cnt_d   = hsync_fall ? LINE_ONE : '0;
        end else if (hsync_fall && (line_cnt_q != LINE_MAX)) begin
            line_cnt_d   = line_cnt_q + LINE_ONE;
        end
    end

    // Deblur only changes on sync cycles so a pixel group always sees one value; interlaced forces it off.
    always_comb begin
        ndo_deblur_d = ndo_deblur_q;
        if (sync_cycle) begin
            ndo_deblur_d = ndeblur_cfg_i | interlaced_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            data_cnt_q   <= 2'd0;
            sync_q       <= 4'hF;
            line_cnt_q   <= '0;
            field_len_q  <= '0;
            vmode_q      <= 1'b0;
            interlaced_q <= 1'b0;
            ndo_deblur_q <= 1'b1;
            n15bit_q     <= 1'b1;
        end else begin
            data_cnt_q   <= data_cnt_d;
            sync_q       <= sync_d;
            line_cnt_q   <= line_cnt_d;
            field_len_q  <= field_len_d;
            vmode_q      <= vmode_d;
            interlaced_q <= interlaced_d;
            ndo_deblur_q <= ndo_deblur_d;
            n15bit_q     <= n15bit_d;
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        demuxparams_o = {data_cnt_q, vmode_q, ndo_deblur_q, n15bit_q};
        vinfo_o       = {interlaced_q, vmode_q};
    end

endmodule

// File: tb/tb_n64_vinfo_gen.sv
// tb_n64_vinfo_gen: directed self-checking bench for n64_vinfo_gen.
module tb_n64_vinfo_gen;

    logic       VCLK;
    logic       nRST;
    logic       nDSYNC;
    logic [6:0] D_i;
    logic       ndeblur_cfg_i;
    logic       n15bit_cfg_i;
    logic [4:0] demuxparams_o;
    logic [1:0] vinfo_o;

    int total;
    int bad;

    n64_vinfo_gen dut (
        .VCLK          (VCLK),
        .nRST          (nRST),
        .nDSYNC        (nDSYNC),
        .D_i           (D_i),
        .ndeblur_cfg_i (ndeblur_cfg_i),
        .n15bit_cfg_i  (n15bit_cfg_i),
        .demuxparams_o (demuxparams_o),
        .vinfo_o       (vinfo_o)
    );

    initial VCLK = 1'b0;
    always #5 VCLK = ~VCLK;

    // Drive one cycle of inputs away from the rising edge.
    task automatic drive(input logic nd, input logic [3:0] s);
        @(negedge VCLK);
        nDSYNC = nd;
        D_i    = {3'b000, s};
    endtask

    // Wait for the edge that captures the last driven inputs, then settle.
    task automatic settle();
        @(posedge VCLK);
        #1;
    endtask

    // n lines, each a falling then rising nHSYNC sample.
    task automatic send_lines(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 4'b1101);
            drive(1'b0, 4'b1111);
        end
    endtask

    // End of field: nVSYNC falls with nHSYNC high.
    task automatic send_vsync();
        drive(1'b0, 4'b0111);
        drive(1'b0, 4'b1111);
    endtask

    // End of field where nHSYNC falls in the same sample as nVSYNC.
    task automatic send_vsync_hfall();
        drive(1'b0, 4'b0101);
        drive(1'b0, 4'b1111);
    endtask

    task automatic send_field(input int n);
        send_lines(n);
        send_vsync();
        settle();
    endtask

    task automatic do_reset();
        @(negedge VCLK);
        nRST   = 1'b0;
        nDSYNC = 1'b1;
        D_i    = 7'h0F;
        @(negedge VCLK);
        @(negedge VCLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge VCLK);
        nRST   = 1'b0;
        nDSYNC = 1'b1;
        D_i    = 7'h0F;
        #2;
        total++;
        if (demuxparams_o !== 5'b00011) begin
            bad++;
            $display("[TB] FAIL reset_demux got=%b want=%b", demuxparams_o, 5'b00011);
        end
        total++;
        if (vinfo_o !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_vinfo got=%b want=%b", vinfo_o, 2'b00);
        end
        @(negedge VCLK);
        nRST = 1'b1;
    endtask

    task automatic test_data_cnt();
        logic [23:0] exp_seq;
        logic [9:0]  early_exp;
        logic [4:0]  early_nd;
        logic [1:0]  exp;
        do_reset();
        exp_seq = 24'b01_10_11_00_01_10_11_00_01_10_11_00;
        for (int i = 0; i < 12; i++) begin
            drive((i % 4) != 0, 4'hF);
            settle();
            exp = exp_seq[23 - 2*i -: 2];
            total++;
            if (demuxparams_o[4:3] !== exp) begin
                bad++;
                $display("[TB] FAIL data_cnt step=%0d got=%b want=%b", i, demuxparams_o[4:3], exp);
            end
        end
        early_nd  = 5'b01011;
        early_exp = 10'b01_10_01_10_11;
        for (int i = 0; i < 5; i++) begin
            drive(early_nd[4 - i], 4'hF);
            settle();
            exp = early_exp[9 - 2*i -: 2];
            total++;
            if (demuxparams_o[4:3] !== exp) begin
                bad++;
                $display("[TB] FAIL data_cnt_early step=%0d got=%b want=%b", i, demuxparams_o[4:3], exp);
            end
        end
    endtask

    task automatic test_progressive();
        logic [1:0] ev;
        logic [4:0] ed;
        ndeblur_cfg_i = 1'b0;
        n15bit_cfg_i  = 1'b1;
        do_reset();
        for (int f = 1; f <= 5; f++) begin
            send_field(263);
            ev = (f == 1) ? 2'b10 : 2'b00;
            ed = (f == 1) ? 5'b01011 : 5'b01001;
            total++;
            if (vinfo_o !== ev) begin
                bad++;
                $display("[TB] FAIL ntsc_vinfo field=%0d got=%b want=%b", f, vinfo_o, ev);
            end
            total++;
            if (demuxparams_o !== ed) begin
                bad++;
                $display("[TB] FAIL ntsc_demux field=%0d got=%b want=%b", f, demuxparams_o, ed);
            end
        end
    endtask

    task automatic test_pal();
        logic [1:0] ev;
        ndeblur_cfg_i = 1'b1;
        n15bit_cfg_i  = 1'b1;
        do_reset();
        for (int f = 1; f <= 5; f++) begin
            send_field(313);
            ev = (f == 1) ? 2'b11 : 2'b01;
            total++;
            if (vinfo_o !== ev) begin
                bad++;
                $display("[TB] FAIL pal_vinfo field=%0d got=%b want=%b", f, vinfo_o, ev);
            end
            total++;
            if (demuxparams_o !== 5'b01111) begin
                bad++;
                $display("[TB] FAIL pal_demux field=%0d got=%b want=%b", f, demuxparams_o, 5'b01111);
            end
        end
    endtask

    task automatic test_interlaced();
        int         lens [5];
        logic [1:0] ev   [5];
        logic [4:0] ed   [5];
        lens = '{263, 263, 262, 263, 262};
        ev   = '{2'b10, 2'b00, 2'b10, 2'b10, 2'b10};
        ed   = '{5'b01011, 5'b01001, 5'b01011, 5'b01011, 5'b01011};
        ndeblur_cfg_i = 1'b0;
        n15bit_cfg_i  = 1'b1;
        do_reset();
        for (int f = 0; f < 5; f++) begin
            send_field(lens[f]);
            total++;
            if (vinfo_o !== ev[f]) begin
                bad++;
                $display("[TB] FAIL ilace_vinfo field=%0d got=%b want=%b", f + 1, vinfo_o, ev[f]);
            end
            total++;
            if (demuxparams_o !== ed[f]) begin
                bad++;
                $display("[TB] FAIL ilace_demux field=%0d got=%b want=%b", f + 1, demuxparams_o, ed[f]);
            end
        end
    endtask

    task automatic test_threshold();
        ndeblur_cfg_i = 1'b0;
        do_reset();
        send_field(287);
        total++;
        if (vinfo_o !== 2'b10) begin
            bad++;
            $display("[TB] FAIL thresh_287 got=%b want=%b", vinfo_o, 2'b10);
        end
        send_field(288);
        total++;
        if (vinfo_o !== 2'b11) begin
            bad++;
            $display("[TB] FAIL thresh_288 got=%b want=%b", vinfo_o, 2'b11);
        end
    endtask

    task automatic test_hv_coincident();
        do_reset();
        send_lines(10);
        send_vsync_hfall();
        settle();
        total++;
        if (vinfo_o !== 2'b10) begin
            bad++;
            $display("[TB] FAIL hv_first got=%b want=%b", vinfo_o, 2'b10);
        end
        send_field(287);
        total++;
        if (vinfo_o !== 2'b11) begin
            bad++;
            $display("[TB] FAIL hv_count got=%b want=%b", vinfo_o, 2'b11);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        send_field(1100);
        total++;
        if (vinfo_o !== 2'b11) begin
            bad++;
            $display("[TB] FAIL sat_first got=%b want=%b", vinfo_o, 2'b11);
        end
        send_field(1100);
        total++;
        if (vinfo_o !== 2'b01) begin
            bad++;
            $display("[TB] FAIL sat_second got=%b want=%b", vinfo_o, 2'b01);
        end
    endtask

    task automatic test_n15bit();
        ndeblur_cfg_i = 1'b0;
        n15bit_cfg_i  = 1'b1;
        do_reset();
        send_field(263);
        total++;
        if (demuxparams_o[0] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL n15_initial got=%b want=%b", demuxparams_o[0], 1'b1);
        end
        n15bit_cfg_i = 1'b0;
        send_lines(100);
        settle();
        total++;
        if (demuxparams_o[0] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL n15_midfield got=%b want=%b", demuxparams_o[0], 1'b1);
        end
        send_lines(163);
        send_vsync();
        settle();
        total++;
        if (demuxparams_o[0] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL n15_after_vsync got=%b want=%b", demuxparams_o[0], 1'b0);
        end
        n15bit_cfg_i = 1'b1;
    endtask

    task automatic test_reset_midfield();
        ndeblur_cfg_i = 1'b0;
        do_reset();
        send_field(313);
        send_field(313);
        send_lines(50);
        @(negedge VCLK);
        #2;
        nRST = 1'b0;
        #1;
        total++;
        if (demuxparams_o !== 5'b00011) begin
            bad++;
            $display("[TB] FAIL midreset_demux got=%b want=%b", demuxparams_o, 5'b00011);
        end
        total++;
        if (vinfo_o !== 2'b00) begin
            bad++;
            $display("[TB] FAIL midreset_vinfo got=%b want=%b", vinfo_o, 2'b00);
        end
        @(negedge VCLK);
        nRST = 1'b1;
        send_field(263);
        total++;
        if (vinfo_o !== 2'b10) begin
            bad++;
            $display("[TB] FAIL midreset_field got=%b want=%b", vinfo_o, 2'b10);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        total         = 0;
        bad           = 0;
        nRST          = 1'b1;
        nDSYNC        = 1'b1;
        D_i           = 7'h0F;
        ndeblur_cfg_i = 1'b0;
        n15bit_cfg_i  = 1'b1;
        test_reset();
        test_data_cnt();
        test_progressive();
        test_pal();
        test_interlaced();
        test_threshold();
        test_hv_coincident();
        test_saturation();
        test_n15bit();
        test_reset_midfield();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
